merge_stream_rx: RTL and testbench
==================================

Name: merge_stream_rx

Overview:
- Receiver directly downstream of the six-chip data merger in the tracking-detector FPGA.
- Deserialises the merged serial event stream: start string, event header, chip headers, clusters and 6-bit CRC.
- Checks CRC, address and format, and pushes tagged 16-bit words into an internal FIFO for the event builder.
- Paces the merger by issuing SendEvt pulses only when FIFO space and the pending-request budget allow.

Parameters:
FIFO_DEPTH, 256, output FIFO depth in 16-bit words (power of 2)
FREE_THRESH, 200, minimum free FIFO words required before issuing SendEvt
MAX_PENDING, 4, maximum outstanding SendEvt requests (counter is 4 bits)

Ports:
Clock  in  1  single system clock; all logic on posedge
Reset  in  1  synchronous, active-low reset
SerIn  in  1  merged serial stream from merger (MergeDataOut), 1 bit/clock, MSB first
Address  in  4  expected board address
SendEvt  out  1  1-clock request for the next event, to merger
WordOut  out  16  {type[3:0], payload[11:0]}, FIFO head
WordValid  out  1  FIFO not empty
WordReady  in  1  consumer pop; pop occurs on WordValid&&WordReady
CrcErr  out  1  1-clock pulse at trailer push when CRC mismatches
FmtErr  out  1  1-clock pulse on format abort
Overflow  out  1  sticky FIFO-overflow flag, cleared only by reset
EvtCount  out  8  completed events (trailers pushed), wraps 255->0

Behaviour:
- Reset (Reset==0 at posedge): state=HUNT, FIFO empty, pending=0, all outputs 0, EvtCount=0, CRC reg=0.
- Stream format: '1','0', addr[3:0], 12-bit event header (NChips=hdr[3:0]), then NChips x (12-bit chip header with NClus=chdr[10:6], then NClus x 12-bit clusters), then 6-bit CRC.
- CRC: CRC-6, polynomial x^6+x+1, init 0, over every bit from the leading '1' through the last cluster bit; compared with the received 6 CRC bits.
- FSM, one bit per clock, 4-bit bit counter BitCnt:
  - HUNT: wait for SerIn=1 -> PRE.
  - PRE: 5 bits (the '0' plus 4 address bits). A first bit of 1 -> FmtErr abort. AddrErr latched if address != Address.
  - EHDR: 12 bits. Then NChips>6 -> abort; NChips==0 -> CRCB; otherwise -> CHDR.
  - CHDR: 12 bits. Then NClus==0 -> next CHDR, or CRCB after the last chip; otherwise -> CLUS.
  - CLUS: 12 bits per cluster; decrement remaining-cluster count, then move to the next chip or CRCB.
  - CRCB: 6 bits -> TRLR.
  - TRLR: 1 cycle; push trailer; back to HUNT.
- Word push happens the cycle after a field's last bit; SerIn continues to be sampled in that cycle, so there are no gaps between fields.
- Word types: 1 = event header, 2 = chip header, 3 = cluster, 4 = trailer.
- Trailer payload = {CrcErr, AddrErr, OvfThisEvt, FmtErr, 2'b00, rxCRC[5:0]}.
- Format abort: push a trailer with FmtErr=1 and rxCRC=0, pulse FmtErr, decrement pending, go to HUNT.
- FIFO:
  - A push when count==FIFO_DEPTH is dropped, sets Overflow and OvfThisEvt, even if a pop happens in the same cycle.
  - A pop when empty is ignored.
  - Simultaneous push and pop with no overflow leaves count unchanged.
- SendEvt:
  - Pulse when pending<MAX_PENDING, free words >= FREE_THRESH, and SendEvt was 0 in the previous cycle.
  - Issuing increments pending; a trailer push (normal or abort) decrements it.
  - Issue and trailer in the same cycle leave pending unchanged; pending never underflows.
  - No SendEvt in the cycle reset deasserts.
- EvtCount increments on every trailer push.
- Reset mid-event discards the partial event and any queued words.

Decomposition:
- Package merge_stream_pkg holds:
  - word type codes (WT_EHDR=1, WT_CHDR=2, WT_CLUS=3, WT_TRLR=4);
  - CRC6_POLY=6'h03;
  - field lengths (HDR_BITS=12, CRC_BITS=6, PRE_BITS=5);
  - MAX_CHIPS=6;
  - NClus field position [10:6];
  - FSM state encodings.
- One sub-module, merge_word_fifo: synchronous 16-bit FIFO with count output.

Test Plan:
- Address=3, stream 1,0,0011, header 12'h0A1, chip header 12'h080, clusters 12'h123 and 12'h456, correct CRC -> words 16'h10A1, 16'h2080, 16'h3123, 16'h3456, then 16'h40xx with bits[11:6]=0; CrcErr stays 0; EvtCount=1.
- Same event with the last CRC bit flipped -> trailer bit11=1, CrcErr pulses once, EvtCount=1.
- Event header NChips=0 (12'h0A0) -> only 16'h10A0 and the trailer; chip header with NClus=0 -> next chip parsed immediately.
- Event header NChips=7 -> FmtErr pulse, trailer 16'h4100, FSM returns to HUNT, and the next valid event decodes correctly.
- WordReady=0 over repeated events with FREE_THRESH=200 -> SendEvt stops once free<200; with FREE_THRESH lowered, overflow sets Overflow and trailer bit9; releasing WordReady drains in order.
- SendEvt pacing: empty FIFO, no events -> exactly 4 pulses spaced >=2 cycles apart, then silence; one completed event -> exactly one more pulse; Reset low mid-event -> all outputs 0, pending=0.

Source files
------------

// File: rtl/merge_stream_pkg.sv
// merge_stream_pkg: shared constants, FSM state encoding and the serial
// CRC-6 step for the merged-stream receiver.
//   Word type codes : upper nibble of every FIFO word
//   Field lengths   : 4-bit constants so they compare directly with BitCnt
//   crc6_step       : one bit of CRC-6 (x^6+x+1), MSB-first
package merge_stream_pkg;

  localparam logic [3:0] WT_EHDR = 4'd1;
  localparam logic [3:0] WT_CHDR = 4'd2;
  localparam logic [3:0] WT_CLUS = 4'd3;
  localparam logic [3:0] WT_TRLR = 4'd4;

  localparam logic [5:0] CRC6_POLY = 6'h03;

  localparam logic [3:0] HDR_BITS = 4'd12;
  localparam logic [3:0] CRC_BITS = 4'd6;
  localparam logic [3:0] PRE_BITS = 4'd5;

  localparam logic [3:0] MAX_CHIPS = 4'd6;

  // Position of the cluster count inside a chip header
  localparam int NCLUS_HI = 10;
  localparam int NCLUS_LO = 6;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_PRE  = 3'd1,
    ST_EHDR = 3'd2,
    ST_CHDR = 3'd3,
    ST_CLUS = 3'd4,
    ST_CRCB = 3'd5,
    ST_TRLR = 3'd6
  } rx_state_e;

  function automatic logic [5:0] crc6_step(input logic [5:0] crc, input logic din);
    logic fb;
    fb = crc[5] ^ din;
    return {crc[4:0], 1'b0} ^ (fb ? CRC6_POLY : 6'h00);
  endfunction

endpackage

// File: rtl/merge_word_fifo.sv
// merge_word_fifo: synchronous single-clock FIFO with occupancy count.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   push_i, din_i  : write request and data; dropped (drop_o=1) when full,
//                    even if a pop happens in the same cycle
//   pop_i          : read request; ignored when empty
//   dout_o         : head word (meaningful only when count_o != 0)
//   count_o        : number of stored words
//   drop_o         : a push was discarded this cycle
module merge_word_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          drop_o
);

  localparam int AW = CW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;
  assign drop_o  = push_i && full;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/merge_stream_rx.sv
// merge_stream_rx: deserialiser for the six-chip merger output stream.
//   Clock, Reset  : system clock, synchronous active-low reset
//   SerIn         : merged serial stream, 1 bit/clock, MSB first
//   Address       : expected board address
//   SendEvt       : 1-clock request for the next event
//   WordOut       : {type[3:0], payload[11:0]} at the FIFO head (0 when empty)
//   WordValid     : FIFO not empty
//   WordReady     : consumer accept
//   CrcErr/FmtErr : 1-clock pulses coincident with the trailer push
//   Overflow      : sticky FIFO overflow flag
//   EvtCount      : trailers pushed, wrapping
//   DbgState      : current receiver state
//   DbgPending    : outstanding SendEvt requests
// Handshake: a word leaves the FIFO on every clock where WordValid && WordReady
// are both high; WordOut holds steady while WordValid is high and WordReady low.
module merge_stream_rx
  import merge_stream_pkg::*;
#(
  parameter int FIFO_DEPTH  = 256,
  parameter int FREE_THRESH = 200,
  parameter int MAX_PENDING = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SerIn,
  input  logic [3:0]  Address,
  output logic        SendEvt,
  output logic [15:0] WordOut,
  output logic        WordValid,
  input  logic        WordReady,
  output logic        CrcErr,
  output logic        FmtErr,
  output logic        Overflow,
  output logic [7:0]  EvtCount,
  output logic [2:0]  DbgState,
  output logic [3:0]  DbgPending
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e   state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  chips_q, chips_d;
  logic [4:0]  clus_q, clus_d;
  logic [5:0]  crc_q, crc_d;
  logic        addr_err_q, addr_err_d;
  logic        ovf_evt_q, ovf_evt_d;
  logic        push_q, push_d;
  logic [15:0] push_word_q, push_word_d;
  logic [3:0]  pending_q, pending_d;
  logic        send_q, ovf_q;
  logic [7:0]  evt_cnt_q;

  logic [11:0]   field;
  logic [4:0]    nclus;
  logic [15:0]   abort_word;
  logic [15:0]   fifo_dout;
  logic [CW-1:0] fifo_count, free_words;
  logic          fifo_drop, trailer_push, issue;

  // Field value including the bit arriving this cycle
  assign field      = {shift_q[10:0], SerIn};
  assign nclus      = field[NCLUS_HI:NCLUS_LO];
  assign abort_word = {WT_TRLR, 1'b0, addr_err_q, ovf_evt_q, 1'b1, 8'h00};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 4'd1;
    shift_d     = field;
    chips_d     = chips_q;
    clus_d      = clus_q;
    crc_d       = crc6_step(crc_q, SerIn);
    addr_err_d  = addr_err_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    unique case (state_q)
      ST_HUNT: begin
        bit_cnt_d = 4'd0;
        crc_d     = SerIn ? crc6_step(6'h00, 1'b1) : 6'h00;
        if (SerIn) begin
          state_d    = ST_PRE;
          addr_err_d = 1'b0;
        end
      end
      ST_PRE: begin
        if (bit_cnt_q == 4'd0 && SerIn) begin
          state_d     = ST_HUNT;
          push_d      = 1'b1;
          push_word_d = abort_word;
        end else if (bit_cnt_q == PRE_BITS - 4'd1) begin
          state_d    = ST_EHDR;
          bit_cnt_d  = 4'd0;
          addr_err_d = (field[3:0] != Address);
        end
      end
      ST_EHDR: begin
        if (bit_cnt_q == HDR_BITS - 4'd1) begin
          bit_cnt_d = 4'd0;
          push_d    = 1'b1;
          if (field[3:0] > MAX_CHIPS) begin
            state_d     = ST_HUNT;
            push_word_d = abort_word;
          end else begin
            push_word_d = {WT_EHDR, field};
            chips_d     = field[3:0];
            state_d     = (field[3:0] == 4'd0) ? ST_CRCB : ST_CHDR;
          end
        end
      end
      ST_CHDR: begin
        if (bit_cnt_q == HDR_BITS - 4'd1) begin
          bit_cnt_d   = 4'd0;
          push_d      = 1'b1;
          push_word_d = {WT_CHDR, field};
          if (nclus != 5'd0) begin
            clus_d  = nclus;
            state_d = ST_CLUS;
          end else if (chips_q == 4'd1) begin
            state_d = ST_CRCB;
          end else begin
            chips_d = chips_q - 4'd1;
          end
        end
      end
      ST_CLUS: begin
        if (bit_cnt_q == HDR_BITS - 4'd1) begin
          bit_cnt_d   = 4'd0;
          push_d      = 1'b1;
          push_word_d = {WT_CLUS, field};
          if (clus_q != 5'd1) begin
            clus_d = clus_q - 5'd1;
          end else if (chips_q == 4'd1) begin
            state_d = ST_CRCB;
          end else begin
            chips_d = chips_q - 4'd1;
            state_d = ST_CHDR;
          end
        end
      end
      ST_CRCB: begin
        crc_d = crc_q;
        if (bit_cnt_q == CRC_BITS - 4'd1) begin
          bit_cnt_d   = 4'd0;
          state_d     = ST_TRLR;
          push_d      = 1'b1;
          push_word_d = {WT_TRLR, (field[5:0] != crc_q), addr_err_q, ovf_evt_q,
                         1'b0, 2'b00, field[5:0]};
        end
      end
      default: begin
        state_d   = ST_HUNT;
        bit_cnt_d = 4'd0;
        crc_d     = 6'h00;
      end
    endcase
  end

  // A drop belongs to the current event until a new start bit is seen
  assign ovf_evt_d = (state_q == ST_HUNT && SerIn) ? 1'b0 : (ovf_evt_q | fifo_drop);

  assign trailer_push = push_q && (push_word_q[15:12] == WT_TRLR);
  assign free_words   = CW'(FIFO_DEPTH) - fifo_count;
  // send_q doubles as "SendEvt was high last cycle", forcing 1-cycle gaps
  assign issue = (pending_q < 4'(MAX_PENDING)) && (free_words >= CW'(FREE_THRESH)) && !send_q;

  always_comb begin
    pending_d = pending_q;
    if (issue && !trailer_push)                        pending_d = pending_q + 4'd1;
    else if (!issue && trailer_push && pending_q != 0) pending_d = pending_q - 4'd1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_HUNT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      chips_q     <= '0;
      clus_q      <= '0;
      crc_q       <= '0;
      addr_err_q  <= 1'b0;
      ovf_evt_q   <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      pending_q   <= '0;
      send_q      <= 1'b0;
      ovf_q       <= 1'b0;
      evt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      chips_q     <= chips_d;
      clus_q      <= clus_d;
      crc_q       <= crc_d;
      addr_err_q  <= addr_err_d;
      ovf_evt_q   <= ovf_evt_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      pending_q   <= pending_d;
      send_q      <= issue;
      ovf_q       <= ovf_q | fifo_drop;
      if (trailer_push) evt_cnt_q <= evt_cnt_q + 8'd1;
    end
  end

  merge_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .push_i  (push_q),
    .din_i   (push_word_q),
    .pop_i   (WordReady),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  assign WordValid  = (fifo_count != '0);
  assign WordOut    = WordValid ? fifo_dout : 16'h0000;
  assign SendEvt    = send_q;
  assign CrcErr     = trailer_push && push_word_q[11];
  assign FmtErr     = trailer_push && push_word_q[8];
  assign Overflow   = ovf_q;
  assign EvtCount   = evt_cnt_q;
  assign DbgState   = state_q;
  assign DbgPending = pending_q;

endmodule

// File: tb/tb_merge_stream_rx.sv
// tb_merge_stream_rx: stream-level bench for merge_stream_rx. Events are built
// as bit queues with a reference CRC-6 computed in the bench; each field end
// pushes the word the receiver should emit onto exp_q, and a monitor pops and
// compares words as they leave the FIFO.
module tb_merge_stream_rx;

  logic        Clock = 1'b0;
  logic        Reset, SerIn, WordReady;
  logic [3:0]  Address;
  logic        SendEvt, WordValid, CrcErr, FmtErr, Overflow;
  logic [15:0] WordOut;
  logic [7:0]  EvtCount;
  logic [2:0]  DbgState;
  logic [3:0]  DbgPending;

  always #5 Clock = ~Clock;

  merge_stream_rx dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SerIn      (SerIn),
    .Address    (Address),
    .SendEvt    (SendEvt),
    .WordOut    (WordOut),
    .WordValid  (WordValid),
    .WordReady  (WordReady),
    .CrcErr     (CrcErr),
    .FmtErr     (FmtErr),
    .Overflow   (Overflow),
    .EvtCount   (EvtCount),
    .DbgState   (DbgState),
    .DbgPending (DbgPending)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] exp_q[$];
  int model_cnt = 0;
  bit ovf_evt   = 0;
  int evt_exp   = 0;
  int exp_crc   = 0;
  int exp_fmt   = 0;
  int send_cnt = 0, gap_viol = 0, crc_pulses = 0, fmt_pulses = 0;
  bit send_prev = 0;

  always @(negedge Clock) begin
    if (WordValid && WordReady) begin
      if (exp_q.size() == 0) check_eq("unexpected_word", {16'h0, WordOut}, 32'h1_0000);
      else begin
        check_eq("word", {16'h0, WordOut}, {16'h0, exp_q.pop_front()});
        model_cnt--;
      end
    end
    if (SendEvt) begin
      send_cnt++;
      if (send_prev) gap_viol++;
    end
    send_prev = SendEvt;
    if (CrcErr) crc_pulses++;
    if (FmtErr) fmt_pulses++;
  end

  // ---------------- stream builder ----------------
  bit          sb_bits[$];
  int          sb_end[$];
  logic [15:0] sb_word[$];
  logic [5:0]  sb_crc;
  int          sb_crc_start;
  logic [11:0] ev_chdr[$];
  logic [11:0] ev_clus[$];

  task automatic add_field(input logic [11:0] v, input int n, input bit in_crc);
    for (int i = n - 1; i >= 0; i--) begin
      bit b;
      b = v[i];
      if (in_crc) sb_crc = {sb_crc[4:0], 1'b0} ^ ((sb_crc[5] ^ b) ? 6'h03 : 6'h00);
      sb_bits.push_back(b);
    end
  endtask

  task automatic mark(input logic [15:0] w);
    sb_end.push_back(sb_bits.size() - 1);
    sb_word.push_back(w);
  endtask

  task automatic build_event(input logic [3:0] addr, input logic [11:0] hdr, input bit flip);
    int ci;
    bit aerr;
    logic [5:0] rx;
    sb_bits.delete(); sb_end.delete(); sb_word.delete();
    sb_crc = 6'h00; sb_crc_start = -1; ci = 0;
    aerr = (addr != Address);
    add_field(12'h001, 1, 1);
    add_field(12'h000, 1, 1);
    add_field({8'h00, addr}, 4, 1);
    add_field(hdr, 12, 1);
    if (hdr[3:0] > 4'd6) begin
      mark({4'h4, 1'b0, aerr, 1'b0, 1'b1, 8'h00});
      return;
    end
    mark({4'h1, hdr});
    for (int c = 0; c < int'(hdr[3:0]); c++) begin
      logic [11:0] ch;
      ch = ev_chdr[c];
      add_field(ch, 12, 1);
      mark({4'h2, ch});
      for (int k = 0; k < int'(ch[10:6]); k++) begin
        add_field(ev_clus[ci], 12, 1);
        mark({4'h3, ev_clus[ci]});
        ci++;
      end
    end
    rx = sb_crc ^ {5'b0, flip};
    sb_crc_start = sb_bits.size();
    add_field({6'h00, rx}, 6, 0);
    mark({4'h4, flip, aerr, 1'b0, 1'b0, 2'b00, rx});
  endtask

  task automatic model_push(input logic [15:0] w);
    if (w[15:12] == 4'h4) begin
      w[9] = w[9] | ovf_evt;
      evt_exp++;
      if (w[11]) exp_crc++;
      if (w[8])  exp_fmt++;
    end
    if (model_cnt < 256) begin
      exp_q.push_back(w);
      model_cnt++;
    end else ovf_evt = 1;
  endtask

  task automatic idle(input int n);
    SerIn = 1'b0;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // pops > 0: raise WordReady for that many cycles inside the CRC field
  task automatic send_stream(input int pops);
    int m;
    m = 0;
    ovf_evt = 0;
    for (int i = 0; i < sb_bits.size(); i++) begin
      if (pops > 0 && sb_crc_start >= 0) begin
        if (i == sb_crc_start + 2)        WordReady = 1'b1;
        if (i == sb_crc_start + 2 + pops) WordReady = 1'b0;
      end
      SerIn = sb_bits[i];
      if (m < sb_end.size() && sb_end[m] == i) begin
        model_push(sb_word[m]);
        m++;
      end
      @(posedge Clock);
      #1;
    end
    idle(4);
  endtask

  task automatic run_event(input logic [3:0] addr, input logic [11:0] hdr, input bit flip, input int pops);
    build_event(addr, hdr, flip);
    send_stream(pops);
    idle(20);
  endtask

  task automatic post_checks(input string tag);
    check_eq({tag, "_evtcount"}, {24'h0, EvtCount}, evt_exp % 256);
    check_eq({tag, "_crcpulses"}, crc_pulses, exp_crc);
    check_eq({tag, "_fmtpulses"}, fmt_pulses, exp_fmt);
    check_eq({tag, "_sendevts"}, send_cnt, 4 + evt_exp);
    check_eq({tag, "_state"}, {29'h0, DbgState}, 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) begin
      @(posedge Clock);
      #1;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sendevt"}, {31'h0, SendEvt}, 0);
    check_eq({tag, "_wordvalid"}, {31'h0, WordValid}, 0);
    check_eq({tag, "_wordout"}, {16'h0, WordOut}, 0);
    check_eq({tag, "_crcerr"}, {31'h0, CrcErr}, 0);
    check_eq({tag, "_fmterr"}, {31'h0, FmtErr}, 0);
    check_eq({tag, "_overflow"}, {31'h0, Overflow}, 0);
    check_eq({tag, "_evtcount"}, {24'h0, EvtCount}, 0);
    check_eq({tag, "_pending"}, {28'h0, DbgPending}, 0);
    check_eq({tag, "_state"}, {29'h0, DbgState}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    Reset = 1'b0; SerIn = 1'b0; WordReady = 1'b1; Address = 4'd3;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_outputs("reset");
    Reset = 1'b1;
    @(negedge Clock);
    check_eq("sendevt_at_release", {31'h0, SendEvt}, 0);
    @(posedge Clock);
    #1;
    idle(20);
    check_eq("pace_pulses", send_cnt, 4);
    check_eq("pace_pending", {28'h0, DbgPending}, 4);

    // basic event, then same event with a corrupted CRC bit
    ev_chdr = '{12'h080};
    ev_clus = '{12'h123, 12'h456};
    run_event(4'd3, 12'h0A1, 1'b0, 0);
    post_checks("basic");
    run_event(4'd3, 12'h0A1, 1'b1, 0);
    post_checks("crcflip");

    // no chips; then a chip with no clusters followed by one with a cluster
    ev_chdr.delete();
    run_event(4'd3, 12'h0A0, 1'b0, 0);
    post_checks("nochips");
    ev_chdr = '{12'h000, 12'h040};
    ev_clus = '{12'h7FF};
    run_event(4'd3, 12'h0A2, 1'b0, 0);
    post_checks("emptychip");

    // too many chips, then recovery; wrong address; bad preamble
    run_event(4'd3, 12'h0A7, 1'b0, 0);
    post_checks("nchips7");
    ev_chdr = '{12'h080};
    ev_clus = '{12'h123, 12'h456};
    run_event(4'd3, 12'h0A1, 1'b0, 0);
    post_checks("recover");
    run_event(4'd5, 12'h0A1, 1'b0, 0);
    post_checks("addrerr");
    sb_bits = '{1'b1, 1'b1};
    sb_end = '{1};
    sb_word = '{16'h4100};
    sb_crc_start = -1;
    send_stream(0);
    idle(20);
    post_checks("preabort");

    // back-pressure: fill, overflow, then drain in order
    WordReady = 1'b0;
    base = send_cnt;
    ev_chdr.delete();
    repeat (6) ev_chdr.push_back(12'h7C0);
    ev_clus.delete();
    for (int i = 0; i < 186; i++) ev_clus.push_back(12'($urandom_range(0, 4095)));
    run_event(4'd3, 12'h0A6, 1'b0, 0);
    check_eq("thresh_no_sendevt", send_cnt, base);
    check_eq("thresh_no_overflow", {31'h0, Overflow}, 0);
    ev_clus.delete();
    for (int i = 0; i < 186; i++) ev_clus.push_back(12'($urandom_range(0, 4095)));
    run_event(4'd3, 12'h0A6, 1'b0, 2);
    check_eq("overflow_set", {31'h0, Overflow}, 1);
    WordReady = 1'b1;
    wait_drain("overflow");
    idle(20);
    check_eq("resume_sendevt", send_cnt, base + 2);
    check_eq("overflow_sticky", {31'h0, Overflow}, 1);
    post_checks("overflow");

    // reset in the middle of an event header
    ev_chdr = '{12'h080};
    ev_clus = '{12'h123, 12'h456};
    build_event(4'd3, 12'h0A1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      SerIn = sb_bits[i];
      @(posedge Clock);
      #1;
    end
    Reset = 1'b0;
    SerIn = 1'b0;
    @(posedge Clock);
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    model_cnt = 0;
    evt_exp = 0;
    send_cnt = 0;
    Reset = 1'b1;
    idle(20);
    check_eq("midreset_pulses", send_cnt, 4);
    run_event(4'd3, 12'h0A1, 1'b0, 0);
    post_checks("after_reset");

    check_eq("sendevt_gaps", gap_viol, 0);
    check_eq("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
